// File: rtl/grf_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grf_multiport: multi-port register file, write bypass, busy scoreboard   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module grf_multiport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rbusy,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*DW-1:0] wd,
  input  logic [NW*32-1:0] wpc,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic [NW-1:0]    trace_valid,
  output logic [NW*32-1:0] trace_pc,
  output logic [NW*AW-1:0] trace_addr,
  output logic [NW*DW-1:0] trace_data
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [NW-1:0]    wkeep;

  logic [NW-1:0]    trace_valid_q;
  logic [NW*32-1:0] trace_pc_q;
  logic [NW*AW-1:0] trace_addr_q;
  logic [NW*DW-1:0] trace_data_q;

  // A write is stored (and bypassed) unless it targets the hardwired zero register.
  always_comb begin
    wkeep = '0;
    for (int j = 0; j < NW; j++) begin
      wkeep[j] = we[j] && !((ZERO_REG != 0) && (wa[j*AW +: AW] == '0));
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    logic [DW-1:0] byp;

    assign addr = ra[i*AW +: AW];

    // Ascending scan so the highest-numbered matching port wins.
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NW; j++) begin
        if (wkeep[j] && (wa[j*AW +: AW] == addr)) begin
          hit = 1'b1;
          byp = wd[j*DW +: DW];
        end
      end
      hit = hit && (BYPASS != 0);
    end

    always_comb begin
      if ((ZERO_REG != 0) && (addr == '0)) begin
        rd[i*DW +: DW] = '0;
        rbusy[i]       = 1'b0;
      end else begin
        rd[i*DW +: DW] = hit ? byp : regs_q[addr];
        rbusy[i]       = busy_q[addr] && !hit;
      end
    end
  end

  // Issue beats a same-cycle write (new producer); flush beats everything.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (we[j]) busy_d[wa[j*AW +: AW]] = 1'b0;
    end
    if (iss_en && !((ZERO_REG != 0) && (iss_addr == '0))) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (flush) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      busy_q        <= '0;
      trace_valid_q <= '0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wkeep[j]) regs_q[wa[j*AW +: AW]] <= wd[j*DW +: DW];
        trace_data_q[j*DW +: DW] <= wkeep[j] ? wd[j*DW +: DW] : '0;
      end
      busy_q        <= busy_d;
      trace_valid_q <= we;
      trace_pc_q    <= wpc;
      trace_addr_q  <= wa;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule
`default_nettype wire

// File: tb/tb_grf_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grf_multiport: directed self-checking bench for grf_multiport (NW=2)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_grf_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NW*32-1:0] wpc;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [NW-1:0]    trace_valid;
  logic [NW*32-1:0] trace_pc;
  logic [NW*AW-1:0] trace_addr;
  logic [NW*DW-1:0] trace_data;

  int n_checks = 0;
  int n_errors = 0;

  grf_multiport #(
    .DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; wpc = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ra    = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    chk("rst_trace_valid", 64'(trace_valid), 64'd0);
    for (int a = 1; a < 32; a++) begin
      ra = {AW'(32 - a), AW'(a)};
      #1;
      chk("rst_rd0", 64'(rd[31:0]), 64'd0);
      chk("rst_rd1", 64'(rd[63:32]), 64'd0);
      chk("rst_rbusy", 64'(rbusy), 64'd0);
    end

    // single write with same-cycle bypass, then trace
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; wpc = {32'd0, 32'h100};
    ra = {5'd1, 5'd5};
    #1;
    chk("byp_rd0", 64'(rd[31:0]), 64'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("stored_rd0", 64'(rd[31:0]), 64'hDEADBEEF);
    chk("tr_valid", 64'(trace_valid), 64'h1);
    chk("tr_addr0", 64'(trace_addr[4:0]), 64'd5);
    chk("tr_data0", 64'(trace_data[31:0]), 64'hDEADBEEF);
    chk("tr_pc0", 64'(trace_pc[31:0]), 64'h100);

    // write to reg 0 is dropped
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'h1234}; wpc = {32'd0, 32'h104};
    ra = {5'd5, 5'd0};
    #1;
    chk("z_rd0", 64'(rd[31:0]), 64'd0);
    tick();
    idle();
    #1;
    chk("z_rd0_after", 64'(rd[31:0]), 64'd0);
    chk("z_tr_valid", 64'(trace_valid), 64'h1);
    chk("z_tr_data", 64'(trace_data[31:0]), 64'd0);
    chk("z_tr_pc", 64'(trace_pc[31:0]), 64'h104);

    // issue then write clears busy
    iss_en = 1'b1; iss_addr = 5'd8; ra = {5'd8, 5'd0};
    #1;
    chk("iss_rbusy_same", 64'(rbusy), 64'd0);
    tick();
    idle();
    #1;
    chk("iss_rbusy", 64'(rbusy), 64'b10);
    we = 2'b01; wa = {5'd0, 5'd8}; wd = {32'd0, 32'h88};
    #1;
    chk("wr_rbusy_byp", 64'(rbusy), 64'd0);
    chk("wr_rd1_byp", 64'(rd[63:32]), 64'h88);
    tick();
    idle();
    #1;
    chk("wr_rbusy_after", 64'(rbusy), 64'd0);

    // issue and write together: busy stays set; flush clears it
    iss_en = 1'b1; iss_addr = 5'd8;
    we = 2'b01; wa = {5'd0, 5'd8}; wd = {32'd0, 32'h99};
    #1;
    chk("iw_rbusy_same", 64'(rbusy), 64'd0);
    tick();
    idle();
    #1;
    chk("iw_rbusy", 64'(rbusy), 64'b10);
    chk("iw_rd1", 64'(rd[63:32]), 64'h99);
    flush = 1'b1;
    #1;
    chk("fl_rbusy_pre", 64'(rbusy), 64'b10);
    tick();
    idle();
    #1;
    chk("fl_rbusy", 64'(rbusy), 64'd0);

    // flush wins over issue; issue to reg 0 ignored
    iss_en = 1'b1; iss_addr = 5'd9; flush = 1'b1; ra = {5'd9, 5'd0};
    tick();
    idle();
    #1;
    chk("fl_over_iss", 64'(rbusy), 64'd0);
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    #1;
    chk("iss_zero", 64'(rbusy), 64'd0);

    // dual write collision: port 1 wins storage and bypass, both traced
    we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'hB, 32'hA}; wpc = {32'h204, 32'h200};
    ra = {5'd0, 5'd3};
    #1;
    chk("dual_byp", 64'(rd[31:0]), 64'hB);
    tick();
    idle();
    #1;
    chk("dual_stored", 64'(rd[31:0]), 64'hB);
    chk("dual_tr_valid", 64'(trace_valid), 64'b11);
    chk("dual_tr_data", 64'(trace_data), {32'hB, 32'hA});
    chk("dual_tr_addr", 64'(trace_addr), 64'({5'd3, 5'd3}));
    chk("dual_tr_pc", 64'(trace_pc), {32'h204, 32'h200});

    // reset overrides write and issue on the same edge
    reset = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
    we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'd0, 32'h55};
    tick();
    reset = 1'b0;
    idle();
    ra = {5'd10, 5'd5};
    #1;
    chk("rst2_rd0", 64'(rd[31:0]), 64'd0);
    chk("rst2_rd1", 64'(rd[63:32]), 64'd0);
    chk("rst2_rbusy", 64'(rbusy), 64'd0);
    chk("rst2_tr_valid", 64'(trace_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
